load_store_unit: RTL and testbench

Executes the data-memory access that the control unit's mem_op / mem_read_type / mem_write_mask fields request, toward a single-outstanding request/acknowledge data bus.
- Sits between the execute stage (ALU address, rs2 data) and data memory.
- Returns the extended load value for the REG_SRC_MEM writeback path.
- Handles byte-lane steering, misalignment detection and bus timeout.

---
 rtl/load_store_unit_pkg.sv | 61 ++++++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory-op fields coming from the
// control unit, the LSU state codes and the access legality helper.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    MEM_RD_BYTE = 3'd0,
    MEM_RD_HALF = 3'd1,
    MEM_RD_WORD = 3'd2,
    MEM_RD_B_U  = 3'd3,
    MEM_RD_H_U  = 3'd4,
    MEM_RD_NONE = 3'd5
  } mem_rd_e;

  localparam logic [3:0] MEM_WR_NONE = 4'b0000;
  localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
  localparam logic [3:0] MEM_WR_HALF = 4'b0011;
  localparam logic [3:0] MEM_WR_WORD = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // True when a load/store cannot be issued: unknown size code or an address
  // not aligned to the access size. Unknown mem_op codes are also refused.
  function automatic logic access_fault(input logic [1:0] op, input logic [2:0] rd_type,
                                        input logic [3:0] wr_mask, input logic [1:0] lane);
    logic fault;
    fault = 1'b1;
    case (op)
      MEM_OP_LOAD: begin
        case (rd_type)
          MEM_RD_BYTE, MEM_RD_B_U: fault = 1'b0;
          MEM_RD_HALF, MEM_RD_H_U: fault = lane[0];
          MEM_RD_WORD:             fault = (lane != 2'b00);
          MEM_RD_NONE:             fault = 1'b1;
          default:                 fault = 1'b1;
        endcase
      end
      MEM_OP_STORE: begin
        case (wr_mask)
          MEM_WR_BYTE: fault = 1'b0;
          MEM_WR_HALF: fault = lane[0];
          MEM_WR_WORD: fault = (lane != 2'b00);
          MEM_WR_NONE: fault = 1'b1;
          default:     fault = 1'b1;
        endcase
      end
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-bus signals of the load/store unit.
// master: the LSU itself (drives the bus); slave: pipeline + memory side.
interface load_store_unit_if;
  logic        start;
  logic [1:0]  mem_op;
  logic [2:0]  mem_read_type;
  logic [3:0]  mem_write_mask;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  start, mem_op, mem_read_type, mem_write_mask, addr, store_data,
    input  bus_ack, bus_rdata,
    output busy, done, load_data, misaligned, bus_error,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output start, mem_op, mem_read_type, mem_write_mask, addr, store_data,
    output bus_ack, bus_rdata,
    input  busy, done, load_data, misaligned, bus_error,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store data replication / byte-enable placement and
// load byte/half extraction with sign or zero extension. Purely combinational.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  st_mask,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store side: shift lane-0 enables to the addressed lane, replicate data
  always_comb begin
    st_be = st_mask << st_lane;
    case (st_mask)
      MEM_WR_BYTE: st_wdata = {4{st_data[7:0]}};
      MEM_WR_HALF: st_wdata = {2{st_data[15:0]}};
      default:     st_wdata = st_data;
    endcase
  end

  // Load side: select the addressed byte/half of the word and extend it
  always_comb begin
    ld_byte_s = ld_rdata[{ld_lane, 3'b000} +: 8];
    ld_half_s = ld_rdata[{ld_lane[1], 4'b0000} +: 16];
    case (ld_type)
      MEM_RD_BYTE: ld_value = {{24{ld_byte_s[7]}}, ld_byte_s};
      MEM_RD_B_U:  ld_value = {24'h000000, ld_byte_s};
      MEM_RD_HALF: ld_value = {{16{ld_half_s[15]}}, ld_half_s};
      MEM_RD_H_U:  ld_value = {16'h0000, ld_half_s};
      MEM_RD_WORD: ld_value = ld_rdata;
      default:     ld_value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one data-memory access per start strobe on a
// single-outstanding req/ack bus, with misalignment refusal and a wait timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.master lsu
);

  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [2:0]        rd_type_r, rd_type_nxt_s;
  logic [1:0]        lane_r, lane_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              mis_r, mis_nxt_s;
  logic              berr_r, berr_nxt_s;
  logic [31:0]       ld_data_r, ld_data_nxt_s;
  logic              req_r, req_nxt_s;
  logic              we_r, we_nxt_s;
  logic [31:0]       baddr_r, baddr_nxt_s;
  logic [3:0]        be_r, be_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;

  logic [3:0]        st_be_s;
  logic [31:0]       st_wdata_s;
  logic [31:0]       ld_value_s;

  lsu_lane_align u_align (
    .st_mask  (lsu.mem_write_mask),
    .st_lane  (lsu.addr[1:0]),
    .st_data  (lsu.store_data),
    .ld_type  (rd_type_r),
    .ld_lane  (lane_r),
    .ld_rdata (lsu.bus_rdata),
    .st_be    (st_be_s),
    .st_wdata (st_wdata_s),
    .ld_value (ld_value_s)
  );

  // Next-state and next-output logic; response flags default to idle values
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    rd_type_nxt_s = rd_type_r;
    lane_nxt_s    = lane_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    mis_nxt_s     = 1'b0;
    berr_nxt_s    = 1'b0;
    ld_data_nxt_s = 32'h0000_0000;
    req_nxt_s     = req_r;
    we_nxt_s      = we_r;
    baddr_nxt_s   = baddr_r;
    be_nxt_s      = be_r;
    wdata_nxt_s   = wdata_r;
    case (state_r)
      LSU_IDLE: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        busy_nxt_s  = 1'b0;
        req_nxt_s   = 1'b0;
        we_nxt_s    = 1'b0;
        baddr_nxt_s = 32'h0000_0000;
        be_nxt_s    = 4'b0000;
        wdata_nxt_s = 32'h0000_0000;
        if (lsu.start) begin
          rd_type_nxt_s = lsu.mem_read_type;
          lane_nxt_s    = lsu.addr[1:0];
          busy_nxt_s    = 1'b1;
          if (lsu.mem_op == MEM_OP_NONE) begin
            state_nxt_s = LSU_RESP;
            done_nxt_s  = 1'b1;
          end else if (access_fault(lsu.mem_op, lsu.mem_read_type,
                                    lsu.mem_write_mask, lsu.addr[1:0])) begin
            state_nxt_s = LSU_RESP;
            done_nxt_s  = 1'b1;
            mis_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = LSU_REQ;
            req_nxt_s   = 1'b1;
            we_nxt_s    = (lsu.mem_op == MEM_OP_STORE);
            baddr_nxt_s = {lsu.addr[31:2], 2'b00};
            if (lsu.mem_op == MEM_OP_STORE) begin
              be_nxt_s    = st_be_s;
              wdata_nxt_s = st_wdata_s;
            end else begin
              be_nxt_s    = 4'b1111;
              wdata_nxt_s = 32'h0000_0000;
            end
          end
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (lsu.bus_ack || (TMO_EN && (cnt_r == TMO_LAST))) begin
          state_nxt_s = LSU_RESP;
          done_nxt_s  = 1'b1;
          req_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
          baddr_nxt_s = 32'h0000_0000;
          be_nxt_s    = 4'b0000;
          wdata_nxt_s = 32'h0000_0000;
          if (lsu.bus_ack) begin
            ld_data_nxt_s = we_r ? 32'h0000_0000 : ld_value_s;
          end else begin
            berr_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      LSU_RESP: begin
        state_nxt_s = LSU_IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = LSU_IDLE;
        busy_nxt_s  = 1'b0;
        req_nxt_s   = 1'b0;
        we_nxt_s    = 1'b0;
        baddr_nxt_s = 32'h0000_0000;
        be_nxt_s    = 4'b0000;
        wdata_nxt_s = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= LSU_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rd_type_r <= 3'd0;
      lane_r    <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      mis_r     <= 1'b0;
      berr_r    <= 1'b0;
      ld_data_r <= 32'h0000_0000;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      baddr_r   <= 32'h0000_0000;
      be_r      <= 4'b0000;
      wdata_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rd_type_r <= rd_type_nxt_s;
      lane_r    <= lane_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      mis_r     <= mis_nxt_s;
      berr_r    <= berr_nxt_s;
      ld_data_r <= ld_data_nxt_s;
      req_r     <= req_nxt_s;
      we_r      <= we_nxt_s;
      baddr_r   <= baddr_nxt_s;
      be_r      <= be_nxt_s;
      wdata_r   <= wdata_nxt_s;
    end
  end

  assign lsu.busy       = busy_r;
  assign lsu.done       = done_r;
  assign lsu.load_data  = ld_data_r;
  assign lsu.misaligned = mis_r;
  assign lsu.bus_error  = berr_r;
  assign lsu.bus_req    = req_r;
  assign lsu.bus_we     = we_r;
  assign lsu.bus_addr   = baddr_r;
  assign lsu.bus_be     = be_r;
  assign lsu.bus_wdata  = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against a byte-level reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, alignment by modulo, lanes by byte index
  function automatic void model(input logic [1:0] op, input logic [2:0] rt, input logic [3:0] mask,
                                input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                                output bit skip, output bit mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size, lane;
    bit sgn;
    logic [31:0] v, m;
    skip = 1'b1; mis = 1'b0; be = 4'h0; wd = 32'h0; ld = 32'h0;
    size = 0; sgn = 1'b0; lane = int'(addr % 32'd4);
    if (op == MEM_OP_LOAD) begin
      case (rt)
        MEM_RD_BYTE: begin size = 1; sgn = 1'b1; end
        MEM_RD_B_U:  size = 1;
        MEM_RD_HALF: begin size = 2; sgn = 1'b1; end
        MEM_RD_H_U:  size = 2;
        MEM_RD_WORD: size = 4;
        default:     size = 0;
      endcase
    end else if (op == MEM_OP_STORE) begin
      case (mask)
        4'b0001: size = 1;
        4'b0011: size = 2;
        4'b1111: size = 4;
        default: size = 0;
      endcase
    end
    if (op == MEM_OP_NONE) return;
    if (size == 0 || (lane % size) != 0) begin mis = 1'b1; return; end
    skip = 1'b0;
    if (op == MEM_OP_STORE) begin
      for (int i = 0; i < 4; i++) begin
        be[i] = (i >= lane) && (i < lane + size);
        wd[8*i +: 8] = sd[8*(i % size) +: 8];
      end
    end else begin
      be = 4'hF;
      v  = rdata >> (8 * lane);
      if (size < 4) begin
        m = (32'd1 << (8 * size)) - 32'd1;
        v = v & m;
        if (sgn && v[8*size-1]) v = v | ~m;
      end
      ld = v;
    end
  endfunction

  // One access: start pulse, bus responder acking at REQ cycle ack_at (<0: never)
  task automatic run_access(input string name, input logic [1:0] op, input logic [2:0] rt,
                            input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int ack_at, input bit poke);
    bit skip, mis, exp_err, seen;
    logic [3:0] be;
    logic [31:0] wd, ld;
    int req_cycles, exp_req, exp_lat, cyc;
    model(op, rt, mask, addr, sd, rdata, skip, mis, be, wd, ld);
    exp_err = !skip && (ack_at < 0 || ack_at >= TMO);
    exp_req = skip ? 0 : (exp_err ? TMO : ack_at + 1);
    exp_lat = skip ? 1 : exp_req + 1;
    if (exp_err) ld = 32'h0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.mem_op = op; bus_if.mem_read_type = rt;
    bus_if.mem_write_mask = mask; bus_if.addr = addr; bus_if.store_data = sd;
    @(negedge clk);
    bus_if.start = 1'b0;
    req_cycles = 0; seen = 1'b0; cyc = 1;
    while (!seen && cyc <= 40) begin
      bus_if.bus_ack = 1'b0;
      if (bus_if.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus_if.bus_req === 1'b1) begin
          check({name, " bus_we"}, 32'(bus_if.bus_we), 32'(op == MEM_OP_STORE));
          check({name, " bus_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
          check({name, " bus_be"}, 32'(bus_if.bus_be), 32'(be));
          if (op == MEM_OP_STORE) check({name, " bus_wdata"}, bus_if.bus_wdata, wd);
          if (req_cycles == ack_at) begin
            bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
          end else begin
            bus_if.bus_rdata = $urandom;
          end
          if (poke && req_cycles == 1) begin
            bus_if.start = 1'b1; bus_if.mem_op = MEM_OP_STORE; bus_if.mem_write_mask = MEM_WR_WORD;
            bus_if.addr = $urandom; bus_if.store_data = $urandom;
          end
          req_cycles++;
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc++;
      end
    end
    bus_if.bus_ack = 1'b0;
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " req_cycles"}, 32'(req_cycles), 32'(exp_req));
    check({name, " misaligned"}, 32'(bus_if.misaligned), 32'(mis));
    check({name, " bus_error"}, 32'(bus_if.bus_error), 32'(exp_err));
    check({name, " load_data"}, bus_if.load_data, ld);
    check({name, " req_at_done"}, 32'(bus_if.bus_req), 32'd0);
    @(negedge clk);
    check({name, " done_pulse"}, 32'(bus_if.done), 32'd0);
    check({name, " busy_after"}, 32'(bus_if.busy), 32'd0);
    check({name, " flags_clear"}, {bus_if.load_data[31:2], bus_if.misaligned, bus_if.bus_error}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] masks [4];
    int r, ack_at;
    masks[0] = MEM_WR_NONE; masks[1] = MEM_WR_BYTE; masks[2] = MEM_WR_HALF; masks[3] = MEM_WR_WORD;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.mem_op = 2'd0; bus_if.mem_read_type = 3'd0;
    bus_if.mem_write_mask = 4'd0; bus_if.addr = 32'd0; bus_if.store_data = 32'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus_if.busy), 32'd0);
    check("reset done", 32'(bus_if.done), 32'd0);
    check("reset bus_req", 32'(bus_if.bus_req), 32'd0);
    check("reset bus_fields", bus_if.bus_addr | bus_if.bus_wdata | 32'(bus_if.bus_be) | 32'(bus_if.bus_we), 32'd0);
    check("reset outputs", bus_if.load_data | 32'(bus_if.misaligned) | 32'(bus_if.bus_error), 32'd0);
    rst = 1'b0;

    run_access("sw", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    run_access("sb", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_BYTE, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0);
    run_access("sh", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_HALF, 32'h102, 32'h1234BEEF, 32'h0, 3, 1'b0);
    run_access("lb", MEM_OP_LOAD, MEM_RD_BYTE, MEM_WR_NONE, 32'h202, 32'h0, 32'h12C35678, 0, 1'b0);
    run_access("lbu", MEM_OP_LOAD, MEM_RD_B_U, MEM_WR_NONE, 32'h202, 32'h0, 32'h12C35678, 0, 1'b0);
    run_access("lh", MEM_OP_LOAD, MEM_RD_HALF, MEM_WR_NONE, 32'h206, 32'h0, 32'h80010000, 1, 1'b0);
    run_access("lhu", MEM_OP_LOAD, MEM_RD_H_U, MEM_WR_NONE, 32'h206, 32'h0, 32'h80010000, 2, 1'b0);
    run_access("lw_mis", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h205, 32'h0, 32'h0, 0, 1'b0);
    run_access("lh_mis", MEM_OP_LOAD, MEM_RD_HALF, MEM_WR_NONE, 32'h201, 32'h0, 32'h0, 0, 1'b0);
    run_access("ld_none", MEM_OP_LOAD, MEM_RD_NONE, MEM_WR_NONE, 32'h200, 32'h0, 32'h0, 0, 1'b0);
    run_access("st_none", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_NONE, 32'h200, 32'h5, 32'h0, 0, 1'b0);
    run_access("op_none", MEM_OP_NONE, MEM_RD_WORD, MEM_WR_WORD, 32'h303, 32'h5, 32'h0, 0, 1'b0);
    run_access("lw_timeout", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h400, 32'h0, 32'h11111111, -1, 1'b1);
    run_access("lw_ack_last", MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h404, 32'h0, 32'hCAFEF00D, TMO - 1, 1'b0);
    run_access("sw_ack_14", MEM_OP_STORE, MEM_RD_NONE, MEM_WR_WORD, 32'h408, 32'h01020304, 32'h0, TMO - 2, 1'b0);

    // Reset during a pending request, then a late acknowledge
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.mem_op = MEM_OP_LOAD; bus_if.mem_read_type = MEM_RD_WORD;
    bus_if.addr = 32'h300;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst pre bus_req", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst busy", 32'(bus_if.busy), 32'd0);
    check("rst done", 32'(bus_if.done), 32'd0);
    rst = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h87654321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      check("late_ack done", 32'(bus_if.done), 32'd0);
      check("late_ack busy", 32'(bus_if.busy), 32'd0);
      check("late_ack load_data", bus_if.load_data, 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      ack_at = r / 2;
      else if (r < 8) ack_at = $urandom_range(3, 8);
      else if (r == 8) ack_at = TMO - 1;
      else            ack_at = -1;
      run_access("rand", 2'($urandom_range(0, 2)), 3'($urandom_range(0, 5)),
                 masks[$urandom_range(0, 3)], $urandom, $urandom, $urandom, ack_at, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
